// File: rtl/vga_box_plotter_pkg.sv
// vga_box_plotter_pkg: screen geometry, bus widths and plotter state encoding
// Shared by the plotter, its bus interface and any sibling plotters or input layers.
package vga_box_plotter_pkg;
  localparam int X_SCREEN_PIXELS = 160;
  localparam int Y_SCREEN_PIXELS = 120;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int COLOUR_W = 3;
  typedef enum logic [2:0] {S_IDLE, S_LOAD_X, S_LOAD_Y, S_DRAW, S_CLEAR, S_DONE} state_t;
endpackage

// File: rtl/vga_box_plotter_if.sv
// vga_box_plotter_if: command inputs and pixel-write outputs of the box plotter
// Ports: i_load_x/i_plot_box/i_black command levels, i_xy_coord shared X/Y bus, i_colour box colour;
// o_x/o_y/o_colour pixel, o_plot write enable, o_busy sweeping, o_done finished.
// slave = plotter side, master = driver side.
interface vga_box_plotter_if;
  import vga_box_plotter_pkg::*;
  logic i_load_x;
  logic i_plot_box;
  logic i_black;
  logic [X_W-1:0] i_xy_coord;
  logic [COLOUR_W-1:0] i_colour;
  logic [X_W-1:0] o_x;
  logic [Y_W-1:0] o_y;
  logic [COLOUR_W-1:0] o_colour;
  logic o_plot;
  logic o_busy;
  logic o_done;
  modport slave(input i_load_x, i_plot_box, i_black, i_xy_coord, i_colour,
                output o_x, o_y, o_colour, o_plot, o_busy, o_done);
  modport master(output i_load_x, i_plot_box, i_black, i_xy_coord, i_colour,
                 input o_x, o_y, o_colour, o_plot, o_busy, o_done);
endinterface

// File: rtl/vga_box_plotter_scan_counter_2d.sv
// scan_counter_2d: raster-order x/y counter with runtime limits
// Ports: i_clk, i_rst (async, high), i_start loads (0,0), i_en advances one step,
// i_lim_x/i_lim_y sweep sizes; o_nx/o_ny next count, o_last current count is final pixel.
module scan_counter_2d #(
  parameter int CX_W = 8,
  parameter int CY_W = 7
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_en,
  input  logic [CX_W:0]   i_lim_x,
  input  logic [CY_W:0]   i_lim_y,
  output logic [CX_W-1:0] o_nx,
  output logic [CY_W-1:0] o_ny,
  output logic            o_last
);
  logic [CX_W-1:0] r_cx;
  logic [CY_W-1:0] r_cy;
  logic w_x_end, w_y_end;
  assign w_x_end = {1'b0, r_cx} == i_lim_x - 1'b1;
  assign w_y_end = {1'b0, r_cy} == i_lim_y - 1'b1;
  assign o_last = w_x_end && w_y_end;
  // Next count is exported so the owner can register outputs for the pixel being entered.
  assign o_nx = i_start ? '0 : i_en ? (w_x_end ? '0 : r_cx + 1'b1) : r_cx;
  assign o_ny = i_start ? '0 : (i_en && w_x_end) ? r_cy + 1'b1 : r_cy;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cx <= '0;
      r_cy <= '0;
    end else begin
      r_cx <= o_nx;
      r_cy <= o_ny;
    end
  end
endmodule

// File: rtl/vga_box_plotter.sv
// vga_box_plotter: sweeps a clipped BOX_W x BOX_H box, or a full-screen clear, into a VGA pixel port
// Ports: i_clk, i_rst (async, high), bus (vga_box_plotter_if.slave) carrying commands and pixel writes.
module vga_box_plotter
  import vga_box_plotter_pkg::*;
#(
  parameter int BOX_W = 4,
  parameter int BOX_H = 4
) (
  input logic i_clk,
  input logic i_rst,
  vga_box_plotter_if.slave bus
);
  localparam int CX_W = $clog2(BOX_W > X_SCREEN_PIXELS ? BOX_W : X_SCREEN_PIXELS);
  localparam int CY_W = $clog2(BOX_H > Y_SCREEN_PIXELS ? BOX_H : Y_SCREEN_PIXELS);
  state_t r_state, w_next;
  logic [X_W-1:0] r_x0, r_x;
  logic [Y_W-1:0] r_y0, r_y;
  logic [COLOUR_W-1:0] r_c0, r_colour;
  logic r_plot, r_busy, r_done;
  logic [CX_W-1:0] w_nx;
  logic [CY_W-1:0] w_ny;
  logic [CX_W:0] w_lim_x;
  logic [CY_W:0] w_lim_y;
  logic [X_W:0] w_px;
  logic [Y_W:0] w_py;
  logic w_last, w_start, w_en, w_drawing, w_clearing, w_clip;
  assign w_drawing = w_next == S_DRAW;
  assign w_clearing = w_next == S_CLEAR;
  assign w_start = (w_drawing && r_state != S_DRAW) || (w_clearing && r_state != S_CLEAR);
  assign w_en = r_state == S_DRAW || r_state == S_CLEAR;
  assign w_lim_x = r_state == S_CLEAR ? (CX_W+1)'(X_SCREEN_PIXELS) : (CX_W+1)'(BOX_W);
  assign w_lim_y = r_state == S_CLEAR ? (CY_W+1)'(Y_SCREEN_PIXELS) : (CY_W+1)'(BOX_H);
  // One extra bit so pixels past the right/bottom edge are detected, not wrapped on-screen.
  assign w_px = (X_W+1)'(r_x0) + (X_W+1)'(w_nx);
  assign w_py = (Y_W+1)'(r_y0) + (Y_W+1)'(w_ny);
  assign w_clip = w_px >= (X_W+1)'(X_SCREEN_PIXELS) || w_py >= (Y_W+1)'(Y_SCREEN_PIXELS);
  scan_counter_2d #(.CX_W(CX_W), .CY_W(CY_W)) u_scan (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(w_start), .i_en(w_en),
    .i_lim_x(w_lim_x), .i_lim_y(w_lim_y), .o_nx(w_nx), .o_ny(w_ny), .o_last(w_last)
  );
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: w_next = bus.i_black ? S_CLEAR : bus.i_plot_box ? S_LOAD_Y :
                               bus.i_load_x ? S_LOAD_X : r_state;
      S_LOAD_X: w_next = bus.i_load_x ? S_LOAD_X : S_IDLE;
      S_LOAD_Y: w_next = bus.i_plot_box ? S_LOAD_Y : S_DRAW;
      S_DRAW, S_CLEAR: w_next = w_last ? S_DONE : r_state;
      default: w_next = S_IDLE;
    endcase
  end
  // Outputs are registered from the next state/count, so the entry edge already presents pixel 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x0 <= '0;
      r_y0 <= '0;
      r_c0 <= '0;
      r_x <= '0;
      r_y <= '0;
      r_colour <= '0;
      r_plot <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_next == S_LOAD_X && r_state != S_LOAD_X) r_x0 <= bus.i_xy_coord;
      if (w_next == S_LOAD_Y && r_state != S_LOAD_Y) begin
        r_y0 <= bus.i_xy_coord[Y_W-1:0];
        r_c0 <= bus.i_colour;
      end
      r_plot <= w_clearing || (w_drawing && !w_clip);
      r_busy <= w_clearing || w_drawing;
      r_done <= w_next == S_DONE;
      if (w_drawing) begin
        r_x <= w_px[X_W-1:0];
        r_y <= w_py[Y_W-1:0];
        r_colour <= r_c0;
      end else if (w_clearing) begin
        r_x <= X_W'(w_nx);
        r_y <= Y_W'(w_ny);
        r_colour <= '0;
      end
    end
  end
  assign bus.o_x = r_x;
  assign bus.o_y = r_y;
  assign bus.o_colour = r_colour;
  assign bus.o_plot = r_plot;
  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
endmodule

// File: tb/tb_vga_box_plotter.sv
// tb_vga_box_plotter: directed self-checking bench for vga_box_plotter
module tb_vga_box_plotter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  vga_box_plotter_if bus();
  vga_box_plotter #(.BOX_W(4), .BOX_H(4)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int n_busy, n_plot;
  bit saw_done;
  logic [2:0] colour_or;
  logic [7:0] px[16];
  logic [6:0] py[16];
  logic pp[16];
  logic [2:0] pc[16];
  logic [7:0] lx;
  logic [6:0] ly;

  task automatic idle_inputs;
    bus.i_load_x = 0; bus.i_plot_box = 0; bus.i_black = 0; bus.i_xy_coord = '0; bus.i_colour = '0;
  endtask
  task automatic load_x(input logic [7:0] x);
    @(negedge clk); bus.i_load_x = 1; bus.i_xy_coord = x;
    @(negedge clk); bus.i_load_x = 0;
  endtask
  task automatic plot_box(input logic [6:0] y, input logic [2:0] c);
    @(negedge clk); bus.i_plot_box = 1; bus.i_xy_coord = {1'b0, y}; bus.i_colour = c;
    @(negedge clk); bus.i_plot_box = 0;
  endtask
  // Records one sweep: first 16 busy cycles in detail, totals for the rest.
  task automatic capture(input int limit);
    n_busy = 0; n_plot = 0; colour_or = '0; saw_done = 0; lx = '0; ly = '0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (!bus.o_busy) begin saw_done = bus.o_done; return; end
      if (n_busy < 16) begin
        px[n_busy] = bus.o_x; py[n_busy] = bus.o_y; pp[n_busy] = bus.o_plot; pc[n_busy] = bus.o_colour;
      end
      if (bus.o_plot) begin n_plot++; lx = bus.o_x; ly = bus.o_y; colour_or |= bus.o_colour; end
      n_busy++;
    end
  endtask

  task automatic test_reset;
    rst = 1; idle_inputs; #1;
    checks++; if (bus.o_x !== 0 || bus.o_y !== 0 || bus.o_colour !== 0) begin errors++; $display("FAIL reset_pixel: got (%0d,%0d,%0d) want (0,0,0)", bus.o_x, bus.o_y, bus.o_colour); end
    checks++; if ({bus.o_plot, bus.o_busy, bus.o_done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {bus.o_plot, bus.o_busy, bus.o_done}); end
    @(negedge clk); rst = 0;
    @(negedge clk);
    checks++; if ({bus.o_plot, bus.o_busy, bus.o_done} !== 3'b000) begin errors++; $display("FAIL idle_flags: got %b want 000", {bus.o_plot, bus.o_busy, bus.o_done}); end
  endtask

  task automatic test_box;
    load_x(8'd10); plot_box(7'd20, 3'b101); capture(100);
    checks++; if (n_busy !== 16) begin errors++; $display("FAIL box_busy: got %0d want 16", n_busy); end
    checks++; if (n_plot !== 16) begin errors++; $display("FAIL box_plot: got %0d want 16", n_plot); end
    for (int k = 0; k < 16; k++) begin
      checks++; if ({pp[k], px[k], py[k], pc[k]} !== {1'b1, 8'(10 + k % 4), 7'(20 + k / 4), 3'd5}) begin errors++; $display("FAIL box_px%0d: got p%0d (%0d,%0d) c%0d want p1 (%0d,%0d) c5", k, pp[k], px[k], py[k], pc[k], 10 + k % 4, 20 + k / 4); end
    end
    checks++; if (!saw_done) begin errors++; $display("FAIL box_done: got 0 want 1"); end
    @(negedge clk);
    checks++; if ({bus.o_plot, bus.o_busy, bus.o_done} !== 3'b001) begin errors++; $display("FAIL box_done_hold: got %b want 001", {bus.o_plot, bus.o_busy, bus.o_done}); end
  endtask

  task automatic test_clip;
    load_x(8'd158); plot_box(7'd118, 3'd2); capture(100);
    checks++; if (n_busy !== 16) begin errors++; $display("FAIL clip_busy: got %0d want 16", n_busy); end
    checks++; if (n_plot !== 4) begin errors++; $display("FAIL clip_plot: got %0d want 4", n_plot); end
    for (int k = 0; k < 16; k++) begin
      checks++; if ({pp[k], px[k], py[k], pc[k]} !== {(158 + k % 4 < 160) && (118 + k / 4 < 120), 8'(158 + k % 4), 7'(118 + k / 4), 3'd2}) begin errors++; $display("FAIL clip_px%0d: got p%0d (%0d,%0d) c%0d want (%0d,%0d)", k, pp[k], px[k], py[k], pc[k], 158 + k % 4, 118 + k / 4); end
    end
    checks++; if (!saw_done) begin errors++; $display("FAIL clip_done: got 0 want 1"); end
  endtask

  task automatic test_clear;
    @(negedge clk); bus.i_black = 1;
    fork
      capture(20000);
      begin @(negedge clk); bus.i_black = 0; end
    join
    checks++; if (n_busy !== 19200 || n_plot !== 19200) begin errors++; $display("FAIL clear_count: got busy %0d plot %0d want 19200", n_busy, n_plot); end
    checks++; if (colour_or !== 0) begin errors++; $display("FAIL clear_colour: got %0d want 0", colour_or); end
    checks++; if (lx !== 159 || ly !== 119) begin errors++; $display("FAIL clear_last: got (%0d,%0d) want (159,119)", lx, ly); end
    for (int k = 0; k < 16; k += 5) begin
      checks++; if (px[k] !== 8'(k) || py[k] !== 0) begin errors++; $display("FAIL clear_px%0d: got (%0d,%0d) want (%0d,0)", k, px[k], py[k], k); end
    end
    checks++; if (!saw_done) begin errors++; $display("FAIL clear_done: got 0 want 1"); end
    plot_box(7'd118, 3'd2); capture(100);
    checks++; if (px[0] !== 158 || py[0] !== 118 || pc[0] !== 2 || n_plot !== 4) begin errors++; $display("FAIL clear_reuse: got (%0d,%0d) c%0d n%0d want (158,118) c2 n4", px[0], py[0], pc[0], n_plot); end
  endtask

  task automatic test_busy_ignore;
    load_x(8'd30); plot_box(7'd40, 3'd6);
    fork
      capture(100);
      begin
        repeat (2) @(negedge clk);
        bus.i_load_x = 1; bus.i_xy_coord = 8'd99; bus.i_colour = 3'd1;
        @(negedge clk); bus.i_plot_box = 1;
        @(negedge clk); bus.i_black = 1;
        @(negedge clk); idle_inputs;
      end
    join
    checks++; if (n_busy !== 16 || n_plot !== 16) begin errors++; $display("FAIL ign_count: got busy %0d plot %0d want 16", n_busy, n_plot); end
    for (int k = 0; k < 16; k++) begin
      checks++; if ({px[k], py[k], pc[k]} !== {8'(30 + k % 4), 7'(40 + k / 4), 3'd6}) begin errors++; $display("FAIL ign_px%0d: got (%0d,%0d) c%0d want (%0d,%0d) c6", k, px[k], py[k], pc[k], 30 + k % 4, 40 + k / 4); end
    end
    plot_box(7'd50, 3'd1); capture(100);
    checks++; if (px[0] !== 30 || py[0] !== 50) begin errors++; $display("FAIL ign_x0: got (%0d,%0d) want (30,50)", px[0], py[0]); end
  endtask

  task automatic test_reset_mid;
    load_x(8'd60); plot_box(7'd60, 3'd7);
    repeat (8) @(negedge clk);
    checks++; if (!bus.o_busy || bus.o_x !== 63 || bus.o_y !== 61) begin errors++; $display("FAIL mid_px7: got b%0d (%0d,%0d) want b1 (63,61)", bus.o_busy, bus.o_x, bus.o_y); end
    #2 rst = 1; #1;
    checks++; if ({bus.o_x, bus.o_y, bus.o_colour, bus.o_plot, bus.o_busy, bus.o_done} !== '0) begin errors++; $display("FAIL mid_reset: got (%0d,%0d) c%0d %b want all 0", bus.o_x, bus.o_y, bus.o_colour, {bus.o_plot, bus.o_busy, bus.o_done}); end
    @(negedge clk); rst = 0;
    repeat (2) @(negedge clk);
    checks++; if ({bus.o_plot, bus.o_busy, bus.o_done} !== 3'b000) begin errors++; $display("FAIL mid_idle: got %b want 000", {bus.o_plot, bus.o_busy, bus.o_done}); end
    load_x(8'd5); plot_box(7'd5, 3'd3); capture(100);
    checks++; if (n_plot !== 16 || !saw_done) begin errors++; $display("FAIL mid_fresh: got n%0d d%0d want n16 d1", n_plot, saw_done); end
    checks++; if (px[0] !== 5 || py[0] !== 5 || px[15] !== 8 || py[15] !== 8 || pc[15] !== 3) begin errors++; $display("FAIL mid_fresh_px: got (%0d,%0d)..(%0d,%0d) c%0d want (5,5)..(8,8) c3", px[0], py[0], px[15], py[15], pc[15]); end
  endtask

  task automatic test_priority;
    @(negedge clk); bus.i_black = 1; bus.i_plot_box = 1; bus.i_xy_coord = 8'd70; bus.i_colour = 3'd4;
    fork
      capture(20000);
      begin @(negedge clk); bus.i_black = 0; end
    join
    checks++; if (n_plot !== 19200 || colour_or !== 0 || !saw_done) begin errors++; $display("FAIL prio_clear: got n%0d c%0d d%0d want n19200 c0 d1", n_plot, colour_or, saw_done); end
    @(negedge clk);
    checks++; if ({bus.o_busy, bus.o_done} !== 2'b00) begin errors++; $display("FAIL prio_load_y: got %b want 00", {bus.o_busy, bus.o_done}); end
    bus.i_plot_box = 0;
    capture(100);
    checks++; if (n_plot !== 16 || px[0] !== 5 || py[0] !== 70 || pc[0] !== 4) begin errors++; $display("FAIL prio_box: got n%0d (%0d,%0d) c%0d want n16 (5,70) c4", n_plot, px[0], py[0], pc[0]); end
  endtask

  initial begin
    test_reset;
    test_box;
    test_clip;
    test_clear;
    test_busy_ignore;
    test_reset_mid;
    test_priority;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
